// File: rtl/tictactoe_board_ctrl_if.sv
// Move handshake between a move source (master) and the tic-tac-toe board controller (slave).
// A move transfers on a clock edge where move_valid and move_ready are both high.
interface tictactoe_board_ctrl_if;
  logic       move_valid;
  logic [3:0] move_pos;
  logic       move_ready;
  logic       move_ack;
  logic       move_err;

  modport master (
    output move_valid, move_pos,
    input  move_ready, move_ack, move_err
  );

  modport slave (
    input  move_valid, move_pos,
    output move_ready, move_ack, move_err
  );
endinterface

// File: rtl/tictactoe_board_ctrl.sv
// Tic-tac-toe board owner: accepts moves over a valid/ready handshake, alternates
// players and resolves win/draw in a registered CHECK cycle after each accepted move.
module tictactoe_board_ctrl #(
  parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        new_game,
  tictactoe_board_ctrl_if.slave       mif,
  output logic [1:0]                  b0,
  output logic [1:0]                  b1,
  output logic [1:0]                  b2,
  output logic [1:0]                  b3,
  output logic [1:0]                  b4,
  output logic [1:0]                  b5,
  output logic [1:0]                  b6,
  output logic [1:0]                  b7,
  output logic [1:0]                  b8,
  output logic [1:0]                  turn,
  output logic [3:0]                  move_count,
  output logic                        game_over,
  output logic [1:0]                  winner,
  output logic                        draw
);

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_CHECK = 2'd1,
    S_OVER  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [8:0][1:0] board_q, board_d;
  logic [1:0]      turn_q, turn_d;
  logic [3:0]      count_q, count_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [1:0]      winner_q, winner_d;
  logic            draw_q, draw_d;
  logic            legal;

  // True when player p owns any of the 8 winning lines of board b.
  function automatic logic line_won(input logic [8:0][1:0] b, input logic [1:0] p);
    logic [8:0] m;
    for (int i = 0; i < 9; i++) m[i] = (b[i] == p);
    return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
           (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
           (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == 2'b01) ? 2'b10 : 2'b01;
  endfunction

  // Positions above 8 never match a cell, so they stay illegal.
  always_comb begin
    legal = 1'b0;
    for (int i = 0; i < 9; i++)
      if (mif.move_pos == 4'(i)) legal = (board_q[i] == 2'b00);
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    turn_d   = turn_q;
    count_d  = count_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    winner_d = winner_q;
    draw_d   = draw_q;

    if (new_game) begin
      state_d  = S_PLAY;
      board_d  = '0;
      turn_d   = FIRST_PLAYER;
      count_d  = 4'd0;
      winner_d = 2'b00;
      draw_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_PLAY: begin
          if (mif.move_valid) begin
            if (legal) begin
              for (int i = 0; i < 9; i++)
                if (mif.move_pos == 4'(i)) board_d[i] = turn_q;
              count_d = count_q + 4'd1;
              ack_d   = 1'b1;
              state_d = S_CHECK;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        // turn_q still names the player who just moved; a win beats a full board.
        S_CHECK: begin
          if (line_won(board_q, turn_q)) begin
            state_d  = S_OVER;
            winner_d = turn_q;
          end else if (count_q == 4'd9) begin
            state_d = S_OVER;
            draw_d  = 1'b1;
          end else begin
            state_d = S_PLAY;
            turn_d  = other_player(turn_q);
          end
        end
        S_OVER:  state_d = S_OVER;
        default: state_d = S_PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_PLAY;
      board_q  <= '0;
      turn_q   <= FIRST_PLAYER;
      count_q  <= 4'd0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      winner_q <= 2'b00;
      draw_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      turn_q   <= turn_d;
      count_q  <= count_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      winner_q <= winner_d;
      draw_q   <= draw_d;
    end
  end

  assign mif.move_ready = (state_q == S_PLAY);
  assign mif.move_ack   = ack_q;
  assign mif.move_err   = err_q;
  assign game_over      = (state_q == S_OVER);
  assign winner         = winner_q;
  assign draw           = draw_q;
  assign turn           = turn_q;
  assign move_count     = count_q;

  assign b0 = board_q[0];
  assign b1 = board_q[1];
  assign b2 = board_q[2];
  assign b3 = board_q[3];
  assign b4 = board_q[4];
  assign b5 = board_q[5];
  assign b6 = board_q[6];
  assign b7 = board_q[7];
  assign b8 = board_q[8];

endmodule

// File: tb/tb_tictactoe_board_ctrl.sv
// Directed bench for tictactoe_board_ctrl: wins, draws, illegal moves, new_game and reset.
module tb_tictactoe_board_ctrl;

  logic       clk;
  logic       rst_n;
  logic       new_game;
  logic [1:0] b0, b1, b2, b3, b4, b5, b6, b7, b8;
  logic [1:0] turn;
  logic [3:0] move_count;
  logic       game_over;
  logic [1:0] winner;
  logic       draw;

  int checks = 0;
  int errors = 0;
  logic [1:0] mb [9];
  int         mcount;

  tictactoe_board_ctrl_if mif ();

  tictactoe_board_ctrl #(.FIRST_PLAYER(2'b01)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .mif(mif.slave),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6), .b7(b7), .b8(b8),
    .turn(turn), .move_count(move_count), .game_over(game_over),
    .winner(winner), .draw(draw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_board(input string tag);
    logic [17:0] obs, exp;
    obs = {b8, b7, b6, b5, b4, b3, b2, b1, b0};
    exp = {mb[8], mb[7], mb[6], mb[5], mb[4], mb[3], mb[2], mb[1], mb[0]};
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 9; i++) mb[i] = 2'b00;
    mcount = 0;
  endtask

  // Present a move and let exactly one edge transfer it; bounded wait for ready.
  task automatic send(input logic [3:0] pos);
    int n;
    n = 0;
    while (mif.move_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(mif.move_ready), 32'd1);
    mif.move_valid = 1'b1;
    mif.move_pos   = pos;
    tick();
    mif.move_valid = 1'b0;
  endtask

  task automatic move_ok(input logic [3:0] pos, input logic [1:0] player);
    send(pos);
    mb[pos] = player;
    mcount++;
    chk("ack", 32'(mif.move_ack), 32'd1);
    chk("err_with_ack", 32'(mif.move_err), 32'd0);
    chk("ready_in_check", 32'(mif.move_ready), 32'd0);
    chk("turn_in_check", 32'(turn), 32'(player));
    check_board("board_after_ack");
    chk("count", 32'(move_count), 32'(mcount));
    tick();
    chk("ack_one_cycle", 32'(mif.move_ack), 32'd0);
  endtask

  task automatic move_bad(input logic [3:0] pos, input logic [1:0] turn_exp);
    send(pos);
    chk("err", 32'(mif.move_err), 32'd1);
    chk("ack_with_err", 32'(mif.move_ack), 32'd0);
    chk("ready_after_err", 32'(mif.move_ready), 32'd1);
    chk("turn_after_err", 32'(turn), 32'(turn_exp));
    chk("count_after_err", 32'(move_count), 32'(mcount));
    check_board("board_after_err");
    tick();
    chk("err_one_cycle", 32'(mif.move_err), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    clear_model();
    check_board({tag, "_board"});
    chk({tag, "_turn"}, 32'(turn), 32'h1);
    chk({tag, "_count"}, 32'(move_count), 32'd0);
    chk({tag, "_ready"}, 32'(mif.move_ready), 32'd1);
    chk({tag, "_ack"}, 32'(mif.move_ack), 32'd0);
    chk({tag, "_err"}, 32'(mif.move_err), 32'd0);
    chk({tag, "_over"}, 32'(game_over), 32'd0);
    chk({tag, "_winner"}, 32'(winner), 32'd0);
    chk({tag, "_draw"}, 32'(draw), 32'd0);
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    new_game = 1'b0;
    mif.move_valid = 1'b0;
    mif.move_pos = 4'd0;
    clear_model();
    tick();
    tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // 1: P1 wins the top row on move 5
    move_ok(4'd0, 2'b01);
    chk("t1_turn2", 32'(turn), 32'h2);
    move_ok(4'd3, 2'b10);
    chk("t1_turn3", 32'(turn), 32'h1);
    move_ok(4'd1, 2'b01);
    move_ok(4'd4, 2'b10);
    chk("t1_not_over", 32'(game_over), 32'd0);
    move_ok(4'd2, 2'b01);
    chk("t1_winner", 32'(winner), 32'h1);
    chk("t1_over", 32'(game_over), 32'd1);
    chk("t1_draw", 32'(draw), 32'd0);
    chk("t1_count", 32'(move_count), 32'd5);
    chk("t1_ready", 32'(mif.move_ready), 32'd0);
    // moves in OVER are ignored
    mif.move_valid = 1'b1;
    mif.move_pos = 4'd5;
    tick();
    chk("over_no_ack", 32'(mif.move_ack), 32'd0);
    chk("over_no_err", 32'(mif.move_err), 32'd0);
    tick();
    mif.move_valid = 1'b0;
    check_board("over_board_held");
    chk("over_winner_held", 32'(winner), 32'h1);
    chk("over_count_held", 32'(move_count), 32'd5);

    // 2: occupied cell, then legal move
    pulse_new_game();
    check_reset_vals("ng1");
    move_ok(4'd4, 2'b01);
    move_bad(4'd4, 2'b10);
    chk("t2_b4", 32'(b4), 32'h1);
    move_ok(4'd5, 2'b10);
    chk("t2_b5", 32'(b5), 32'h2);
    chk("t2_turn", 32'(turn), 32'h1);

    // 3: out-of-range positions
    move_bad(4'd9, 2'b01);
    move_bad(4'd15, 2'b01);
    chk("t3_count", 32'(move_count), 32'd2);

    // 4: full board, no line
    pulse_new_game();
    check_reset_vals("ng2");
    move_ok(4'd0, 2'b01); move_ok(4'd1, 2'b10); move_ok(4'd2, 2'b01);
    move_ok(4'd4, 2'b10); move_ok(4'd3, 2'b01); move_ok(4'd5, 2'b10);
    move_ok(4'd7, 2'b01); move_ok(4'd6, 2'b10);
    chk("t4_not_over", 32'(game_over), 32'd0);
    move_ok(4'd8, 2'b01);
    chk("t4_draw", 32'(draw), 32'd1);
    chk("t4_winner", 32'(winner), 32'd0);
    chk("t4_over", 32'(game_over), 32'd1);
    chk("t4_count", 32'(move_count), 32'd9);

    // 5: ninth move wins column 0
    pulse_new_game();
    check_reset_vals("ng3");
    move_ok(4'd0, 2'b01); move_ok(4'd1, 2'b10); move_ok(4'd2, 2'b01);
    move_ok(4'd4, 2'b10); move_ok(4'd3, 2'b01); move_ok(4'd5, 2'b10);
    move_ok(4'd7, 2'b01); move_ok(4'd8, 2'b10);
    move_ok(4'd6, 2'b01);
    chk("t5_winner", 32'(winner), 32'h1);
    chk("t5_draw", 32'(draw), 32'd0);
    chk("t5_over", 32'(game_over), 32'd1);
    chk("t5_count", 32'(move_count), 32'd9);

    // 6: new_game beats a simultaneous transfer
    pulse_new_game();
    clear_model();
    move_ok(4'd0, 2'b01);
    new_game = 1'b1;
    mif.move_valid = 1'b1;
    mif.move_pos = 4'd1;
    tick();
    new_game = 1'b0;
    mif.move_valid = 1'b0;
    check_reset_vals("ng_with_move");

    // new_game beats the CHECK result
    send(4'd4);
    chk("t6_ack", 32'(mif.move_ack), 32'd1);
    pulse_new_game();
    check_reset_vals("ng_in_check");

    // async reset mid-CHECK
    send(4'd0);
    chk("t6_b0_set", 32'(b0), 32'h1);
    chk("t6_ready_check", 32'(mif.move_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals("rst_in_check");
    rst_n = 1'b1;
    tick();
    check_reset_vals("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
